// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   size_e  : access size coding (same as MemRead/MemWrite)
//   state_e : responder FSM states
//   be_from : byte enables for a size / low address pair
//   misaligned : half on odd address, word on non-word address
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, byte-enable write, registered read.
// Not reset; contents survive responder reset.
//   clk   : clock
//   addr  : word index
//   we/be : write strobe and byte enables
//   wdata : lane-aligned write data
//   re    : read strobe, rdata updates on the next edge
//   rdata : registered read word
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with LATENCY wait cycles.
// Optional macro DMEM_LOAD_SIGN_EXT_EN: byte/half loads sign-extend (lb/lh);
// otherwise they zero-extend (lbu/lhu).
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_write, req_size, req_addr, req_wdata : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                       : response channel
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
`ifdef DMEM_LOAD_SIGN_EXT_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W+1:0] addr_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic [31:0]      wdata_q;

  logic             idle;
  logic [IDX_W+1:0] cur_addr;
  logic [1:0]       cur_size;
  logic             cur_write;
  logic [31:0]      cur_wdata;
  logic             commit;
  logic             cur_ok;
  logic [31:0]      rd_word;
  logic [31:0]      sh;
  logic [31:0]      ld_data;
  logic             err_now;
  logic             unused_addr;

  assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

  assign idle      = (state_q == ST_IDLE);
  assign req_ready = idle;
  assign rsp_valid = (state_q == ST_RESP);

  // With LATENCY=0 the commit edge is the accept edge, so the array must see
  // the live request rather than the latched copy.
  assign cur_addr  = idle ? req_addr[IDX_W+1:0] : addr_q;
  assign cur_size  = idle ? req_size : size_q;
  assign cur_write = idle ? req_write : write_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;

  assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign cur_ok = !misaligned(cur_size, cur_addr[1:0]) && (cur_size != SZ_NONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= SZ_NONE;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req_valid) begin
        addr_q  <= req_addr[IDX_W+1:0];
        size_q  <= req_size;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .addr (cur_addr[IDX_W+1:2]),
    .we   (commit && cur_write && cur_ok),
    .be   (be_from(cur_size, cur_addr[1:0])),
    .wdata(cur_wdata << {cur_addr[1:0], 3'b000}),
    .re   (commit && !cur_write && cur_ok),
    .rdata(rd_word)
  );

  // Latched request fields and the array's read register are both frozen in
  // RESP, so the response below is stable without a separate output register.
  assign err_now = misaligned(size_q, addr_q[1:0]);
  assign sh      = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = 32'd0;
    case (size_q)
      SZ_BYTE: ld_data = {{24{SIGN_EXT & sh[7]}}, sh[7:0]};
      SZ_HALF: ld_data = {{16{SIGN_EXT & sh[15]}}, sh[15:0]};
      SZ_WORD: ld_data = rd_word;
      default: ld_data = 32'd0;
    endcase
  end

  assign rsp_err   = rsp_valid && err_now;
  assign rsp_rdata = (rsp_valid && !write_q && !err_now) ? ld_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT [2] = '{2, 0};

  logic        reset     [2];
  logic        req_valid [2];
  logic        req_write [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_rdata [2];

  int checks = 0;
  int failures = 0;

  // reference storage: 16-word window per DUT (addresses are built so that
  // index bits above bit 5 are always zero)
  logic [31:0] mdl [2][16];

  dmem_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble(input int s);
    req_valid[s] = 1'($urandom);
    req_write[s] = 1'($urandom);
    req_size[s]  = 2'($urandom);
    req_addr[s]  = $urandom;
    req_wdata[s] = $urandom;
  endtask

  // Build an address whose storage index lands in the model window, with
  // random bits above the storage index to exercise wrap-around.
  function automatic logic [31:0] mk_addr(input int word, input int lo);
    logic [31:0] r;
    r = $urandom;
    return {r[31:10], 4'b0000, 4'(word), 2'(lo)};
  endfunction

  // Reference behaviour: returns expected error flag and load data, and
  // applies any store to the model.
  task automatic model(input int s, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic exp_err, output logic [31:0] exp_rd);
    int lane, nb, w;
    logic [31:0] v;
    lane = int'(a[1:0]);
    w    = int'(a[5:2]);
    exp_err = (sz == 2'd2 && a[0]) || (sz == 2'd3 && a[1:0] != 2'b00);
    exp_rd  = 32'd0;
    if (!exp_err && sz != 2'd0) begin
      nb = 1 << (int'(sz) - 1);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (b >= lane && b < lane + nb) mdl[s][w][8*b +: 8] = wd[8*(b-lane) +: 8];
      end else begin
        v = mdl[s][w] >> (8 * lane);
        if (nb == 4) exp_rd = v;
`ifdef DMEM_LOAD_SIGN_EXT_EN
        else if (nb == 1) exp_rd = {{24{v[7]}}, v[7:0]};
        else exp_rd = {{16{v[15]}}, v[15:0]};
`else
        else if (nb == 1) exp_rd = {24'd0, v[7:0]};
        else exp_rd = {16'd0, v[15:0]};
`endif
      end
    end
  endtask

  task automatic txn(input int s, input bit wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] got);
    logic e_err;
    logic [31:0] e_rd, first;
    int lat;
    model(s, wr, sz, a, wd, e_err, e_rd);
    @(negedge clk);
    req_valid[s] = 1'b1; req_write[s] = wr; req_size[s] = sz;
    req_addr[s] = a; req_wdata[s] = wd; rsp_ready[s] = 1'b0;
    chk("idle_ready", 32'(req_ready[s]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    scramble(s);
    lat = 0;
    while (!rsp_valid[s] && lat < 40) begin
      chk("busy_ready", 32'(req_ready[s]), 32'd0);
      @(negedge clk);
      scramble(s);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT[s]));
    chk("rsp_err", 32'(rsp_err[s]), 32'(e_err));
    chk("rsp_rdata", rsp_rdata[s], e_rd);
    chk("resp_ready", 32'(req_ready[s]), 32'd0);
    got = rsp_rdata[s];
    first = rsp_rdata[s];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      scramble(s);
      chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
      chk("hold_rdata", rsp_rdata[s], first);
      chk("hold_ready", 32'(req_ready[s]), 32'd0);
    end
    req_valid[s] = 1'b0;
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    chk("post_ready", 32'(req_ready[s]), 32'd1);
    chk("post_valid", 32'(rsp_valid[s]), 32'd0);
  endtask

  logic [31:0] got;
  logic [31:0] save;
  logic        d_err;
  logic [31:0] d_rd;

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b0; req_valid[s] = 1'b0; req_write[s] = 1'b0; req_size[s] = 2'd0;
      req_addr[s] = 32'd0; req_wdata[s] = 32'd0; rsp_ready[s] = 1'b0;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(req_ready[s]), 32'd1);
      chk("rst_valid", 32'(rsp_valid[s]), 32'd0);
      chk("rst_rdata", rsp_rdata[s], 32'd0);
      chk("rst_err", 32'(rsp_err[s]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset[0] = 1'b1; reset[1] = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        txn(s, 1'b1, 2'd3, mk_addr(w, 0), $urandom, 0, got);

    // word store/load
    txn(0, 1'b1, 2'd3, 32'h10, 32'hDEADBEEF, 0, got);
    txn(0, 1'b0, 2'd3, 32'h10, 32'h0, 0, got);
    chk("word_load", got, 32'hDEADBEEF);

    // byte store then byte/word loads
    txn(0, 1'b1, 2'd3, 32'h10, 32'h0, 0, got);
    txn(0, 1'b1, 2'd1, 32'h13, 32'h80, 0, got);
    txn(0, 1'b0, 2'd1, 32'h13, 32'h0, 0, got);
`ifdef DMEM_LOAD_SIGN_EXT_EN
    chk("byte_load", got, 32'hFFFFFF80);
`else
    chk("byte_load", got, 32'h00000080);
`endif
    txn(0, 1'b0, 2'd3, 32'h10, 32'h0, 0, got);
    chk("word_after_byte", got, 32'h80000000);

    // misaligned half leaves memory alone
    txn(0, 1'b0, 2'd2, 32'h11, 32'h0, 0, got);
    txn(0, 1'b1, 2'd2, 32'h11, 32'h1234, 0, got);
    txn(0, 1'b0, 2'd3, 32'h10, 32'h0, 0, got);
    chk("word_after_mis", got, 32'h80000000);

    // long backpressure with toggling request inputs
    txn(0, 1'b0, 2'd3, 32'h10, 32'h0, 5, got);
    txn(1, 1'b0, 2'd2, 32'h6, 32'h0, 5, got);

    // reset during WAIT of a store aborts it
    save = mdl[0][8];
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd3;
    req_addr[0] = 32'h20; req_wdata[0] = ~save;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset[0] = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready[0]), 32'd1);
    chk("abort_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_rdata", rsp_rdata[0], 32'd0);
    @(negedge clk);
    reset[0] = 1'b1;
    txn(0, 1'b0, 2'd3, 32'h20, 32'h0, 0, got);
    chk("abort_kept", got, save);

    // index wrap
    for (int s = 0; s < 2; s++) begin
      txn(s, 1'b1, 2'd3, 32'h400, 32'hA5C3_0F96, 0, got);
      txn(s, 1'b0, 2'd3, 32'h000, 32'h0, 0, got);
      chk("wrap", got, 32'hA5C3_0F96);
    end

    // size none completes without error or store
    txn(1, 1'b1, 2'd0, 32'h0, 32'hFFFF_FFFF, 0, got);
    model(1, 1'b0, 2'd3, 32'h0, 32'h0, d_err, d_rd);
    txn(1, 1'b0, 2'd3, 32'h0, 32'h0, 0, got);
    chk("none_nostore", got, 32'hA5C3_0F96);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      int s;
      s = i % 2;
      txn(s, 1'($urandom), 2'($urandom), mk_addr($urandom_range(15, 0), $urandom_range(3, 0)),
          $urandom, $urandom_range(3, 0), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
